framebuffer_writer_ci: RTL and testbench

Nios II custom-instruction slave that fills the 1-bit-per-pixel 64x64 image RAM scanned out by the VGA display stage. It accepts pixel-write, block-fill and 32-pixel word-write commands from the CPU and drives the RAM write port (data, wraddress, wren) in the CPU clock domain. It sits directly upstream of the display block; the display reads the same RAM on its own read port.

---
 rtl/framebuffer_writer_ci.sv | 143 ++++++++++++++
 tb/tb_framebuffer_writer_ci.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer_ci.sv
// framebuffer_writer_ci: Nios II custom instruction filling the 1bpp image RAM (optional BOUNDS_CHECK_EN).
module framebuffer_writer_ci #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 6,
  localparam int ADDR_W = X_BITS + Y_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic [31:0]       result,
  output logic              done,
  output logic              wr_data,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_en
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [2:0] {IDLE, PIXEL, FILL, WORD, DONE} state_t;
  state_t state, state_n;
  logic [31:0] result_n, cnt, cnt_n, word, word_n;
  logic [4:0] idx, idx_n;
  logic done_n, wr_data_n, wr_en_n;
  logic [ADDR_W-1:0] wr_address_n;
  logic unused_datab;
  assign unused_datab = ^datab[29:ADDR_W];
`ifdef BOUNDS_CHECK_EN
  logic [15:0] px, py;
  logic oob;
  assign px = dataa[15:0];
  assign py = dataa[31:16];
  assign oob = (|px[15:X_BITS]) | (|py[15:Y_BITS]);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      result <= '0;
      done <= 1'b0;
      wr_en <= 1'b0;
      wr_data <= 1'b0;
      wr_address <= '0;
      cnt <= '0;
      word <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      result <= result_n;
      done <= done_n;
      wr_en <= wr_en_n;
      wr_data <= wr_data_n;
      wr_address <= wr_address_n;
      cnt <= cnt_n;
      word <= word_n;
      idx <= idx_n;
    end
  // The write counter tracks actual RAM write cycles, so it runs even while clk_en stalls the FSM.
  always_comb begin
    state_n = state;
    result_n = result;
    done_n = done;
    wr_en_n = 1'b0;
    wr_data_n = wr_data;
    wr_address_n = wr_address;
    cnt_n = cnt + 32'(wr_en);
    word_n = word;
    idx_n = idx;
    if (clk_en)
      case (state)
        IDLE:
          if (start)
            case (datab[31:30])
              2'b00: begin
`ifdef BOUNDS_CHECK_EN
                if (oob) begin
                  state_n = DONE;
                  done_n = 1'b1;
                  result_n = '1;
                end else begin
                  state_n = PIXEL;
                  wr_en_n = 1'b1;
                  wr_data_n = datab[0];
                  wr_address_n = {py[Y_BITS-1:0], px[X_BITS-1:0]};
                end
`else
                state_n = PIXEL;
                wr_en_n = 1'b1;
                wr_data_n = datab[0];
                wr_address_n = dataa[ADDR_W-1:0];
`endif
              end
              2'b01: begin
                state_n = FILL;
                wr_en_n = 1'b1;
                wr_data_n = datab[0];
                wr_address_n = '0;
              end
              2'b10: begin
                state_n = WORD;
                wr_en_n = 1'b1;
                wr_data_n = dataa[31];
                wr_address_n = datab[ADDR_W-1:0];
                word_n = dataa;
                idx_n = 5'd31;
              end
              default: begin
                state_n = DONE;
                done_n = 1'b1;
                result_n = cnt;
              end
            endcase
        PIXEL: begin
          state_n = DONE;
          done_n = 1'b1;
          result_n = 32'd1;
        end
        FILL:
          if (wr_address == ADDR_W'(DEPTH - 1)) begin
            state_n = DONE;
            done_n = 1'b1;
            result_n = 32'(DEPTH);
          end else begin
            wr_en_n = 1'b1;
            wr_address_n = wr_address + ADDR_W'(1);
          end
        WORD:
          if (idx == 5'd0) begin
            state_n = DONE;
            done_n = 1'b1;
            result_n = 32'd32;
          end else begin
            wr_en_n = 1'b1;
            idx_n = idx - 5'd1;
            wr_data_n = word[idx - 5'd1];
            wr_address_n = wr_address + ADDR_W'(1);
          end
        default: begin
          state_n = IDLE;
          done_n = 1'b0;
        end
      endcase
  end
endmodule

// File: tb/tb_framebuffer_writer_ci.sv
// tb_framebuffer_writer_ci: table-driven and randomized checks against a command-level reference model.
module tb_framebuffer_writer_ci;
  logic clk = 0, reset, clk_en, start, done, wr_data, wr_en;
  logic [31:0] dataa, datab, result;
  logic [11:0] wr_address;
  int checks = 0, errors = 0;
  logic [12:0] obs[$], exp_q[$];
  logic [31:0] exp_res, tot;
  int exp_lat;

  typedef struct {
    string name;
    logic [31:0] a, b;
    int stall_at, stall_len;
    bit keep;
    logic [31:0] res;
    int lat, nw;
  } vec_t;
  vec_t tbl[$];

  framebuffer_writer_ci dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
    .result(result), .done(done), .wr_data(wr_data), .wr_address(wr_address), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name);
    int bad = -1;
    checks++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
    if (bad >= 0 || obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s writes: %0d writes (first bad index %0d, got %0h) expected %0d writes (%0h)",
               name, obs.size(), bad, bad >= 0 ? obs[bad] : 13'h0, exp_q.size(),
               bad >= 0 ? exp_q[bad] : 13'h0);
    end
  endtask

  // Command-level model: the list of (address, pixel) writes, result and unstalled latency.
  task automatic model(input logic [31:0] a, input logic [31:0] b);
    int x, y;
    exp_q.delete();
    case (b[31:30])
      2'b00: begin
`ifdef BOUNDS_CHECK_EN
        x = int'(a[15:0]);
        y = int'(a[31:16]);
        if (x >= 64 || y >= 64) begin
          exp_res = 32'hFFFF_FFFF;
          exp_lat = 1;
        end else begin
          exp_q.push_back({12'(y * 64 + x), b[0]});
          exp_res = 1;
          exp_lat = 2;
        end
`else
        x = int'(a[11:0]);
        y = 0;
        exp_q.push_back({12'(x), b[0]});
        exp_res = 1;
        exp_lat = 2;
`endif
      end
      2'b01: begin
        for (int i = 0; i < 4096; i++) exp_q.push_back({12'(i), b[0]});
        exp_res = 4096;
        exp_lat = 4097;
      end
      2'b10: begin
        for (int k = 31; k >= 0; k--) exp_q.push_back({12'((int'(b[11:0]) + 31 - k) % 4096), a[k]});
        exp_res = 32;
        exp_lat = 33;
      end
      default: begin
        exp_res = tot;
        exp_lat = 1;
      end
    endcase
    tot += 32'(exp_q.size());
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input int stall_at,
                         input int stall_len, input bit keep, output logic [31:0] res, output int lat);
    obs.delete();
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1;
    clk_en = 1;
    lat = 0;
    res = 'x;
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      if (!keep) start = 0;
      if (wr_en) obs.push_back({wr_address, wr_data});
      if (c == stall_at) clk_en = 0;
      if (c == stall_at + stall_len) clk_en = 1;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
    start = 0;
    clk_en = 1;
  endtask

  initial begin
    logic [31:0] res, a, b, r;
    int lat, st, sl, n;
    reset = 1;
    start = 0;
    clk_en = 0;
    dataa = 0;
    datab = 0;
    tot = 0;
    repeat (2) @(negedge clk);
    chk("reset result", result, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset wr_en", {31'b0, wr_en}, 0);
    chk("reset wr_data", {31'b0, wr_data}, 0);
    chk("reset wr_address", {20'b0, wr_address}, 0);
    reset = 0;
    clk_en = 1;

    // Abort a fill at address 100 with an asynchronous reset.
    @(negedge clk);
    datab = 32'h4000_0001;
    start = 1;
    n = 0;
    for (int c = 0; c < 300 && !(wr_en && wr_address == 12'd100); c++) begin
      @(negedge clk);
      start = 0;
    end
    chk("fill reached 100", {20'b0, wr_address}, 100);
    reset = 1;
    #1;
    chk("abort wr_en", {31'b0, wr_en}, 0);
    chk("abort done", {31'b0, done}, 0);
    @(negedge clk);
    reset = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(done) + int'(wr_en);
    end
    chk("no activity after abort", n, 0);
    tot = 0;
    model(32'h0, 32'hC000_0000);
    run_cmd(32'h0, 32'hC000_0000, 0, 0, 0, res, lat);
    chk("status after abort", res, 0);

    tbl.push_back('{"pixel",
`ifdef BOUNDS_CHECK_EN
                    32'h0001_0001,
`else
                    32'h0000_0041,
`endif
                    32'h0000_0001, 0, 0, 0, 32'd1, 2, 1});
    tbl.push_back('{"fill", 32'h0, 32'h4000_0000, 0, 0, 0, 32'd4096, 4097, 4096});
    tbl.push_back('{"word", 32'hA000_0001, 32'h8000_0FF0, 0, 0, 0, 32'd32, 33, 32});
    tbl.push_back('{"word stall", 32'hA000_0001, 32'h8000_0FF0, 10, 5, 0, 32'd32, 38, 32});
    tbl.push_back('{"word busy start", 32'h1234_5678, 32'h8000_0FFE, 0, 0, 1, 32'd32, 33, 32});
    tbl.push_back('{"status", 32'h0, 32'hC000_0000, 0, 0, 0, 32'd4193, 1, 0});
`ifdef BOUNDS_CHECK_EN
    tbl.push_back('{"pixel oob", 32'h0003_0040, 32'h0000_0001, 0, 0, 0, 32'hFFFF_FFFF, 1, 0});
    tbl.push_back('{"pixel xy", 32'h0003_0005, 32'h0000_0001, 0, 0, 0, 32'd1, 2, 1});
    tbl.push_back('{"status2", 32'h0, 32'hC000_0000, 0, 0, 0, 32'd4194, 1, 0});
`endif
    foreach (tbl[i]) begin
      model(tbl[i].a, tbl[i].b);
      run_cmd(tbl[i].a, tbl[i].b, tbl[i].stall_at, tbl[i].stall_len, tbl[i].keep, res, lat);
      chk({tbl[i].name, " result"}, res, tbl[i].res);
      chk({tbl[i].name, " latency"}, lat, tbl[i].lat);
      chk({tbl[i].name, " count"}, obs.size(), tbl[i].nw);
      chk_seq(tbl[i].name);
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      a = $urandom();
      b = $urandom();
      b[31:30] = r[1:0] == 2'b01 ? 2'b11 : r[1:0];
      st = r[4:2] == 3'd0 ? int'($urandom_range(1, 30)) : 0;
      sl = int'($urandom_range(1, 4));
      model(a, b);
      run_cmd(a, b, st, sl, r[5], res, lat);
      chk("rand result", res, exp_res);
      chk("rand latency", lat, exp_lat + ((st > 0 && st < exp_lat) ? sl : 0));
      chk_seq("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
